// File: rtl/uart_cmd_sequencer_if.sv
// Byte-receive handshake, framebuffer write port and status for uart_cmd_sequencer.
// master = the sequencer, slave = the receiver/framebuffer side.
interface uart_cmd_sequencer_if #(
    parameter int ADDR_W = 16
) ();
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              rx_error;
    logic              rx_ack;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic              busy;
    logic              err_pulse;

    modport master (
        input  rx_data, rx_ready, rx_error, wr_ready,
        output rx_ack, wr_addr, wr_data, wr_valid, busy, err_pulse
    );

    modport slave (
        output rx_data, rx_ready, rx_error, wr_ready,
        input  rx_ack, wr_addr, wr_data, wr_valid, busy, err_pulse
    );
endinterface

// File: rtl/uart_cmd_sequencer.sv
// UART command sequencer: parses 'W' write-burst and 'C' clear packets into framebuffer writes.
// Optional CMD_CHECKSUM_EN: every packet carries a trailing XOR checksum byte.
module uart_cmd_sequencer #(
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 1_066_666
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_cmd_sequencer_if.master  bus
);
    localparam int           TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR_H, S_ADDR_L, S_LEN, S_DATA, S_WRITE,
        S_FILL_VAL, S_FILL, S_W_CSUM, S_C_CSUM
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_ack_d;
    logic              r_err;
    logic [TW-1:0]     r_tmo;
    logic [7:0]        r_addr_h;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_data;
    logic [8:0]        r_rem;
    logic              w_wait;
    logic              w_take;
    logic              w_tmo_hit;
    logic              w_err;
    logic              w_csum_ok;

`ifdef CMD_CHECKSUM_EN
    logic [7:0] r_csum;
    assign w_csum_ok = (bus.rx_data == r_csum);
`else
    assign w_csum_ok = 1'b1;
`endif

    // rx_ready is still stale the cycle after an ack, so r_ack_d masks it.
    always_comb begin
        w_wait = 1'b0;
        case (r_state)
            S_IDLE, S_ADDR_H, S_ADDR_L, S_LEN, S_DATA,
            S_FILL_VAL, S_W_CSUM, S_C_CSUM: w_wait = 1'b1;
            default: w_wait = 1'b0;
        endcase
        w_take    = w_wait && bus.rx_ready && !r_ack_d;
        w_tmo_hit = w_wait && (r_state != S_IDLE) && !w_take && (r_tmo == TMO_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_err        = 1'b0;
        if (w_take && bus.rx_error) begin
            w_state_next = S_IDLE;
            w_err        = 1'b1;
        end else if (w_tmo_hit) begin
            w_state_next = S_IDLE;
            w_err        = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        if (bus.rx_data == 8'h57)      w_state_next = S_ADDR_H;
                        else if (bus.rx_data == 8'h43) w_state_next = S_FILL_VAL;
                        else                           w_err        = 1'b1;
                    end
                end
                S_ADDR_H: if (w_take) w_state_next = S_ADDR_L;
                S_ADDR_L: if (w_take) w_state_next = S_LEN;
                S_LEN:    if (w_take) w_state_next = S_DATA;
                S_DATA:   if (w_take) w_state_next = S_WRITE;
                S_WRITE: begin
                    if (bus.wr_ready) begin
                        if (r_rem == 9'd1) begin
`ifdef CMD_CHECKSUM_EN
                            w_state_next = S_W_CSUM;
`else
                            w_state_next = S_IDLE;
`endif
                        end else begin
                            w_state_next = S_DATA;
                        end
                    end
                end
                S_FILL_VAL: begin
                    if (w_take) begin
`ifdef CMD_CHECKSUM_EN
                        w_state_next = S_C_CSUM;
`else
                        w_state_next = S_FILL;
`endif
                    end
                end
                S_C_CSUM: begin
                    if (w_take) begin
                        w_state_next = w_csum_ok ? S_FILL : S_IDLE;
                        w_err        = !w_csum_ok;
                    end
                end
                S_W_CSUM: begin
                    if (w_take) begin
                        w_state_next = S_IDLE;
                        w_err        = !w_csum_ok;
                    end
                end
                S_FILL: if (bus.wr_ready && (&r_addr)) w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ack_d  <= 1'b0;
            r_err    <= 1'b0;
            r_tmo    <= '0;
            r_addr_h <= '0;
            r_addr   <= '0;
            r_data   <= '0;
            r_rem    <= '0;
        end else begin
            r_ack_d <= w_take;
            r_err   <= w_err;
            // Timeout only advances while waiting for a byte mid-packet; write stalls hold it.
            if (w_take || r_state == S_IDLE) begin
                r_tmo <= '0;
            end else if (w_wait) begin
                r_tmo <= r_tmo + TW'(1);
            end
            if (w_take) begin
                case (r_state)
                    S_ADDR_H:   r_addr_h <= bus.rx_data;
                    S_ADDR_L:   r_addr   <= ADDR_W'({r_addr_h, bus.rx_data});
                    S_LEN:      r_rem    <= {(bus.rx_data == 8'd0), bus.rx_data};
                    S_DATA:     r_data   <= bus.rx_data;
                    S_FILL_VAL: begin
                        r_data <= bus.rx_data;
                        r_addr <= '0;
                    end
                    default: ;
                endcase
            end
            if (bus.wr_ready && (r_state == S_WRITE || r_state == S_FILL)) begin
                r_addr <= r_addr + ADDR_W'(1);
                if (r_state == S_WRITE) r_rem <= r_rem - 9'd1;
            end
        end
    end

`ifdef CMD_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_csum <= '0;
        end else if (w_take) begin
            r_csum <= (r_state == S_IDLE) ? bus.rx_data : (r_csum ^ bus.rx_data);
        end
    end
`endif

    assign bus.rx_ack    = w_take;
    assign bus.wr_valid  = (r_state == S_WRITE) || (r_state == S_FILL);
    assign bus.wr_addr   = r_addr;
    assign bus.wr_data   = r_data;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.err_pulse = r_err;
endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Randomized scoreboard bench for uart_cmd_sequencer (ADDR_W=8, short timeout).
module tb_uart_cmd_sequencer;
    localparam int AW  = 8;
    localparam int FB  = 1 << AW;
    localparam int TMO = 300;

    typedef struct packed { logic [7:0] a; logic [7:0] d; } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_cmd_sequencer_if #(.ADDR_W(AW)) bus ();
    uart_cmd_sequencer #(.ADDR_W(AW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int  checks = 0;
    int  failures = 0;
    int  exp_acks = 0;
    int  acks_seen = 0;
    int  exp_err = 0;
    int  err_seen = 0;
    bit  rdy_hold = 1'b0;
    wr_t exp_q[$];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Write-port ready: random, or forced low while rdy_hold is set.
    initial begin
        bus.wr_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.wr_ready = rdy_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops the scoreboard on every accepted write.
    initial begin
        bit         prev_pend = 1'b0;
        logic [7:0] prev_a = '0;
        logic [7:0] prev_d = '0;
        wr_t        e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_pend = 1'b0;
            end else begin
                if (bus.rx_ack) begin
                    acks_seen++;
                    chk("ack_while_wr_valid", int'(bus.wr_valid), 0);
                end
                if (bus.err_pulse) err_seen++;
                if (prev_pend) begin
                    checks++;
                    if (!bus.wr_valid || bus.wr_addr != prev_a || bus.wr_data != prev_d) begin
                        failures++;
                        $display("FAIL wr_stable actual=v%0d a%02h d%02h required=v1 a%02h d%02h",
                                 bus.wr_valid, bus.wr_addr, bus.wr_data, prev_a, prev_d);
                    end
                end
                if (bus.wr_valid && bus.wr_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_write actual=a%02h d%02h required=none",
                                 bus.wr_addr, bus.wr_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (bus.wr_addr != e.a || bus.wr_data != e.d) begin
                            failures++;
                            $display("FAIL write actual=a%02h d%02h required=a%02h d%02h",
                                     bus.wr_addr, bus.wr_data, e.a, e.d);
                        end
                    end
                end
                prev_pend = bus.wr_valid && !bus.wr_ready;
                prev_a    = bus.wr_addr;
                prev_d    = bus.wr_data;
            end
        end
    end

    task automatic present(input logic [7:0] b, input bit e);
        bus.rx_data  = b;
        bus.rx_error = e;
        bus.rx_ready = 1'b1;
    endtask

    // Receiver model: after the ack it keeps the flag one more cycle, then clears it.
    task automatic wait_ack(input logic [7:0] b);
        bit got = 1'b0;
        for (int i = 0; i < 4000 && !got; i++) begin
            @(negedge clk);
            if (bus.rx_ack) got = 1'b1;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL byte_ack actual=no_ack required=ack byte=%02h", b);
            bus.rx_ready = 1'b0;
            return;
        end
        exp_acks++;
        tick(1);
        tick(1);
        bus.rx_ready = 1'b0;
        bus.rx_error = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit e);
        present(b, e);
        wait_ack(b);
        tick($urandom_range(0, 3));
    endtask

    task automatic send_packet(input logic [7:0] bytes[$]);
        logic [7:0] x = 8'h00;
        foreach (bytes[i]) begin
            send_byte(bytes[i], 1'b0);
            x ^= bytes[i];
        end
`ifdef CMD_CHECKSUM_EN
        send_byte(x, 1'b0);
`endif
    endtask

    // Reference: a burst writes consecutive addresses modulo FB starting at {H,L} mod FB.
    task automatic w_packet(input logic [15:0] addr, input logic [7:0] len, input logic [7:0] data[$]);
        logic [7:0] bytes[$];
        int n = (len == 0) ? 256 : int'(len);
        int base = int'(addr) % FB;
        bytes = {8'h57, addr[15:8], addr[7:0], len};
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{a: 8'((base + i) % FB), d: data[i]});
            bytes.push_back(data[i]);
        end
        send_packet(bytes);
    endtask

    task automatic c_packet(input logic [7:0] fill);
        logic [7:0] bytes[$];
        for (int i = 0; i < FB; i++) exp_q.push_back('{a: 8'(i), d: fill});
        bytes = {8'h43, fill};
        send_packet(bytes);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 5000 && exp_q.size() != 0; i++) @(negedge clk);
        chk({name, "_pending_writes"}, exp_q.size(), 0);
        exp_q.delete();
        tick(5);
        chk({name, "_busy"}, int'(bus.busy), 0);
        chk({name, "_err_count"}, err_seen, exp_err);
    endtask

    initial begin
        logic [7:0] d[$];
        logic [7:0] op;
        bus.rx_data  = 8'h00;
        bus.rx_ready = 1'b0;
        bus.rx_error = 1'b0;
        rst = 1'b1;
        tick(3);
        @(negedge clk);
        chk("rst_wr_valid", int'(bus.wr_valid), 0);
        chk("rst_rx_ack", int'(bus.rx_ack), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_err", int'(bus.err_pulse), 0);
        chk("rst_wr_addr", int'(bus.wr_addr), 0);
        chk("rst_wr_data", int'(bus.wr_data), 0);
        tick(1);
        rst = 1'b0;
        tick(2);

        // Basic burst and address wrap.
        d = {8'hAA, 8'hBB, 8'hCC};
        w_packet(16'h0102, 8'd3, d);
        drain("burst3");
        d = {8'h11, 8'h22};
        w_packet(16'h00FF, 8'd2, d);
        drain("wrap");

        // Write stalled 20 cycles: outputs hold, next byte not acked.
        exp_q.push_back('{a: 8'h10, d: 8'hAA});
        exp_q.push_back('{a: 8'h11, d: 8'hBB});
        rdy_hold = 1'b1;
        send_byte(8'h57, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h10, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'hAA, 1'b0);
        present(8'hBB, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("stall_valid", int'(bus.wr_valid), 1);
            chk("stall_ack", int'(bus.rx_ack), 0);
        end
        chk("stall_addr", int'(bus.wr_addr), 8'h10);
        rdy_hold = 1'b0;
        wait_ack(8'hBB);
`ifdef CMD_CHECKSUM_EN
        send_byte(8'h57 ^ 8'h00 ^ 8'h10 ^ 8'h02 ^ 8'hAA ^ 8'hBB, 1'b0);
`endif
        drain("stall");

        // Timeout mid-packet, then a full clear.
        send_byte(8'h57, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h10, 1'b0);
        exp_err++;
        tick(TMO + 30);
        chk("timeout_err", err_seen, exp_err);
        chk("timeout_busy", int'(bus.busy), 0);
        c_packet(8'h5A);
        drain("fill");

        // Bad opcode and rx_error on LEN.
        send_byte(8'h99, 1'b0);
        exp_err++;
        drain("bad_opcode");
        send_byte(8'h57, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'h03, 1'b1);
        exp_err++;
        drain("rx_error");

`ifdef CMD_CHECKSUM_EN
        send_byte(8'h43, 1'b0);
        send_byte(8'h5A, 1'b0);
        send_byte(8'h00, 1'b0);
        exp_err++;
        drain("bad_csum");
`endif

        // LEN=0 means 256 bytes, wrapping the address.
        d.delete();
        for (int i = 0; i < 256; i++) d.push_back(8'($urandom));
        w_packet(16'h12F0, 8'd0, d);
        drain("len256");

        // Random traffic.
        for (int p = 0; p < 15; p++) begin
            if ($urandom_range(0, 9) == 0) begin
                op = 8'($urandom);
                if (op == 8'h57 || op == 8'h43) op = 8'h00;
                send_byte(op, 1'b0);
                exp_err++;
            end else begin
                d.delete();
                op = 8'($urandom_range(1, 6));
                for (int i = 0; i < int'(op); i++) d.push_back(8'($urandom));
                w_packet(16'($urandom), op, d);
            end
        end
        drain("random");

        // Reset in the middle of a fill.
        c_packet(8'h77);
        for (int i = 0; i < 3000 && exp_q.size() > 200; i++) @(negedge clk);
        chk("fill_progress", int'(exp_q.size() <= 200), 1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_mid_fill_valid", int'(bus.wr_valid), 0);
        chk("rst_mid_fill_busy", int'(bus.busy), 0);
        exp_q.delete();
        tick(2);
        rst = 1'b0;
        tick(50);
        chk("post_rst_busy", int'(bus.busy), 0);

        chk("total_acks", acks_seen, exp_acks);
        chk("total_errs", err_seen, exp_err);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
